// File: rtl/am29xx_pkg.sv
// Shared code constants and the ALU function for the am29xx bit-slice pair.
package am29xx_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned RF_DEPTH = 16;
    localparam int unsigned STK_D    = 4;
    localparam int unsigned SP_W     = 2;

    localparam logic [2:0] SRC_AQ = 3'd0;
    localparam logic [2:0] SRC_AB = 3'd1;
    localparam logic [2:0] SRC_ZQ = 3'd2;
    localparam logic [2:0] SRC_ZB = 3'd3;
    localparam logic [2:0] SRC_ZA = 3'd4;
    localparam logic [2:0] SRC_DA = 3'd5;
    localparam logic [2:0] SRC_DQ = 3'd6;
    localparam logic [2:0] SRC_DZ = 3'd7;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUBR  = 3'd1;
    localparam logic [2:0] OP_SUBS  = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_NOTRS = 3'd5;
    localparam logic [2:0] OP_EXOR  = 3'd6;
    localparam logic [2:0] OP_EXNOR = 3'd7;

    localparam logic [2:0] DST_QREG  = 3'd0;
    localparam logic [2:0] DST_NOP   = 3'd1;
    localparam logic [2:0] DST_RAMA  = 3'd2;
    localparam logic [2:0] DST_RAMF  = 3'd3;
    localparam logic [2:0] DST_RAMQD = 3'd4;
    localparam logic [2:0] DST_RAMD  = 3'd5;
    localparam logic [2:0] DST_RAMQU = 3'd6;
    localparam logic [2:0] DST_RAMU  = 3'd7;

    localparam logic [1:0] SEL_PC  = 2'd0;
    localparam logic [1:0] SEL_AR  = 2'd1;
    localparam logic [1:0] SEL_STK = 2'd2;
    localparam logic [1:0] SEL_D   = 2'd3;

    typedef struct packed {
        logic [DATA_W-1:0] f;
        logic              cout;
        logic              ovr;
    } alu_res_t;

    // Arithmetic ops share one adder; subtraction inverts an operand and relies on cin.
    function automatic alu_res_t alu_func(input logic [2:0] op, input logic [DATA_W-1:0] r,
                                          input logic [DATA_W-1:0] s, input logic cin);
        alu_res_t          res;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] low;
        logic              arith;
        x     = r;
        y     = s;
        arith = 1'b1;
        case (op)
            OP_SUBR: x = ~r;
            OP_SUBS: y = ~s;
            OP_ADD:  x = r;
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + (DATA_W+1)'(cin);
        low = {1'b0, x[DATA_W-2:0]} + {1'b0, y[DATA_W-2:0]} + DATA_W'(cin);
        res.f = sum[DATA_W-1:0];
        case (op)
            OP_OR:    res.f = r | s;
            OP_AND:   res.f = r & s;
            OP_NOTRS: res.f = ~r & s;
            OP_EXOR:  res.f = r ^ s;
            OP_EXNOR: res.f = ~(r ^ s);
            default:  res.f = sum[DATA_W-1:0];
        endcase
        res.cout = arith & sum[DATA_W];
        res.ovr  = arith & (low[DATA_W-1] ^ sum[DATA_W]);
        return res;
    endfunction

endpackage

// File: rtl/am29xx_seq.sv
// Microprogram sequencer slice: uPC, address register, 4-deep stack, Y mux.
// SEQ_2909_EN selects Am2909 behaviour (rin feeds AR, orin ORed into Y); default is Am2911.
module am29xx_seq
    import am29xx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] rin,
    input  logic [DATA_W-1:0] orin,
    input  logic              s0,
    input  logic              s1,
    input  logic              zero,
    input  logic              cin,
    input  logic              re,
    input  logic              fe,
    input  logic              pup,
    output logic [DATA_W-1:0] yout,
    output logic              cout
);

    logic [DATA_W-1:0] upc;
    logic [DATA_W-1:0] ar;
    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] stk [STK_D];
    logic [SP_W-1:0]   sp_inc;
    logic [DATA_W-1:0] src_c;
    logic [DATA_W-1:0] or_mask;
    logic [DATA_W-1:0] ar_d;
    logic [DATA_W-1:0] y_c;

`ifdef SEQ_2909_EN
    assign or_mask = orin;
    assign ar_d    = rin;
`else
    logic unused_2909_inputs;
    assign unused_2909_inputs = ^{rin, orin};
    assign or_mask = '0;
    assign ar_d    = din;
`endif

    assign sp_inc = sp + SP_W'(1);

    // Source select; the stack source always shows the pre-edge top entry.
    always_comb begin
        src_c = upc;
        case ({s1, s0})
            SEL_AR:  src_c = ar;
            SEL_STK: src_c = stk[sp];
            SEL_D:   src_c = din;
            default: src_c = upc;
        endcase
    end

    assign y_c  = zero ? (src_c | or_mask) : '0;
    assign yout = y_c;
    assign cout = cin & (y_c == {DATA_W{1'b1}});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            upc <= '0;
            ar  <= '0;
            sp  <= '0;
            for (int i = 0; i < STK_D; i++) begin
                stk[i] <= '0;
            end
        end else begin
            upc <= y_c + DATA_W'(cin);
            if (!re) begin
                ar <= ar_d;
            end
            if (!fe) begin
                if (pup) begin
                    sp          <= sp_inc;
                    stk[sp_inc] <= upc;
                end else begin
                    sp <= sp - SP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/am29xx_slice.sv
// Am2901-style ALU slice plus an Am2909/Am2911-style sequencer slice (am29xx_seq).
// Build option SEQ_2909_EN is consumed by the sequencer.
module am29xx_slice
    import am29xx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_din,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [2:0]        alu_src,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        alu_dest,
    input  logic              alu_cin,
    output logic [DATA_W-1:0] alu_yout,
    output logic              alu_cout,
    output logic              alu_f0,
    output logic              alu_f3,
    output logic              alu_ovr,
    input  logic [DATA_W-1:0] seq_din,
    input  logic [DATA_W-1:0] seq_rin,
    input  logic [DATA_W-1:0] seq_orin,
    input  logic              seq_s0,
    input  logic              seq_s1,
    input  logic              seq_zero,
    input  logic              seq_cin,
    input  logic              seq_re,
    input  logic              seq_fe,
    input  logic              seq_pup,
    output logic [DATA_W-1:0] seq_yout,
    output logic              seq_cout
);

    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] s_c;
    alu_res_t          res_c;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wd;
    logic              q_we;
    logic [DATA_W-1:0] q_wd;
    logic [DATA_W-1:0] y_c;

    assign a_data = rf[alu_a];
    assign b_data = rf[alu_b];

    // Operand selection.
    always_comb begin
        r_c = '0;
        s_c = '0;
        case (alu_src)
            SRC_AQ: begin r_c = a_data;  s_c = q;      end
            SRC_AB: begin r_c = a_data;  s_c = b_data; end
            SRC_ZQ: s_c = q;
            SRC_ZB: s_c = b_data;
            SRC_ZA: s_c = a_data;
            SRC_DA: begin r_c = alu_din; s_c = a_data; end
            SRC_DQ: begin r_c = alu_din; s_c = q;      end
            default: r_c = alu_din;
        endcase
    end

    assign res_c = alu_func(alu_op, r_c, s_c, alu_cin);

    // Destination decode; shifts fill with zero.
    always_comb begin
        rf_we = 1'b0;
        rf_wd = res_c.f;
        q_we  = 1'b0;
        q_wd  = res_c.f;
        y_c   = res_c.f;
        case (alu_dest)
            DST_QREG: q_we = 1'b1;
            DST_RAMA: begin rf_we = 1'b1; y_c = a_data; end
            DST_RAMF: rf_we = 1'b1;
            DST_RAMQD: begin
                rf_we = 1'b1;
                rf_wd = res_c.f >> 1;
                q_we  = 1'b1;
                q_wd  = q >> 1;
            end
            DST_RAMD: begin rf_we = 1'b1; rf_wd = res_c.f >> 1; end
            DST_RAMQU: begin
                rf_we = 1'b1;
                rf_wd = res_c.f << 1;
                q_we  = 1'b1;
                q_wd  = q << 1;
            end
            DST_RAMU: begin rf_we = 1'b1; rf_wd = res_c.f << 1; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (rf_we) begin
                rf[alu_b] <= rf_wd;
            end
            if (q_we) begin
                q <= q_wd;
            end
        end
    end

    assign alu_yout = y_c;
    assign alu_cout = res_c.cout;
    assign alu_ovr  = res_c.ovr;
    assign alu_f0   = (res_c.f == '0);
    assign alu_f3   = res_c.f[DATA_W-1];

    am29xx_seq u_seq (
        .clock (clock),
        .reset (reset),
        .din   (seq_din),
        .rin   (seq_rin),
        .orin  (seq_orin),
        .s0    (seq_s0),
        .s1    (seq_s1),
        .zero  (seq_zero),
        .cin   (seq_cin),
        .re    (seq_re),
        .fe    (seq_fe),
        .pup   (seq_pup),
        .yout  (seq_yout),
        .cout  (seq_cout)
    );

endmodule

// File: tb/tb_am29xx_slice.sv
// Scoreboard bench for am29xx_slice: expectations queued at drive time, popped at sample time.
module tb_am29xx_slice;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] alu_din, alu_a, alu_b;
    logic [2:0] alu_src, alu_op, alu_dest;
    logic       alu_cin;
    logic [3:0] alu_yout;
    logic       alu_cout, alu_f0, alu_f3, alu_ovr;
    logic [3:0] seq_din, seq_rin, seq_orin;
    logic       seq_s0, seq_s1, seq_zero, seq_cin, seq_re, seq_fe, seq_pup;
    logic [3:0] seq_yout;
    logic       seq_cout;

    int checks = 0;
    int errors = 0;

    logic [7:0] alu_exp [$];
    string      alu_name [$];
    logic [4:0] seq_exp [$];
    string      seq_name [$];

    typedef struct packed {
        logic [2:0] src, op, dest;
        logic [3:0] a, b, din;
        logic       cin;
        logic [3:0] y, f;
        logic       cout, ovr;
    } alu_vec_t;

    typedef struct packed {
        logic [1:0] s;
        logic [3:0] din, rin, orin;
        logic       zero, cin, re, fe, pup;
        logic [3:0] y;
        logic       cout;
    } seq_vec_t;

`ifdef SEQ_2909_EN
    localparam logic [3:0] AR_Y = 4'h7;
    localparam logic [3:0] OR_Y = 4'hA;
`else
    localparam logic [3:0] AR_Y = 4'h5;
    localparam logic [3:0] OR_Y = 4'h8;
`endif

    am29xx_slice dut (
        .clock(clock), .reset(reset),
        .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
        .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
        .alu_yout(alu_yout), .alu_cout(alu_cout), .alu_f0(alu_f0), .alu_f3(alu_f3),
        .alu_ovr(alu_ovr),
        .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
        .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero(seq_zero), .seq_cin(seq_cin),
        .seq_re(seq_re), .seq_fe(seq_fe), .seq_pup(seq_pup),
        .seq_yout(seq_yout), .seq_cout(seq_cout)
    );

    always #5 clock = ~clock;

    function automatic alu_vec_t av(input logic [2:0] src, op, dest, input logic [3:0] a, b, din,
                                    input logic cin, input logic [3:0] y, f,
                                    input logic cout, ovr);
        return '{src, op, dest, a, b, din, cin, y, f, cout, ovr};
    endfunction

    function automatic seq_vec_t sq(input logic [1:0] s, input logic [3:0] din, rin, orin,
                                    input logic zero, cin, re, fe, pup,
                                    input logic [3:0] y, input logic cout);
        return '{s, din, rin, orin, zero, cin, re, fe, pup, y, cout};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        alu_din = 4'h0; alu_a = 4'h0; alu_b = 4'h0;
        alu_src = 3'd7; alu_op = 3'd3; alu_dest = 3'd1; alu_cin = 1'b0;
        seq_din = 4'h0; seq_rin = 4'h0; seq_orin = 4'h0;
        seq_s0 = 1'b0; seq_s1 = 1'b0; seq_zero = 1'b1; seq_cin = 1'b0;
        seq_re = 1'b1; seq_fe = 1'b1; seq_pup = 1'b0;
    endtask

    task automatic drive_alu(input string n, input alu_vec_t v);
        alu_src = v.src; alu_op = v.op; alu_dest = v.dest;
        alu_a = v.a; alu_b = v.b; alu_din = v.din; alu_cin = v.cin;
        alu_exp.push_back({v.y, v.cout, (v.f == 4'h0), v.f[3], v.ovr});
        alu_name.push_back(n);
    endtask

    task automatic drive_seq(input string n, input seq_vec_t v);
        {seq_s1, seq_s0} = v.s;
        seq_din = v.din; seq_rin = v.rin; seq_orin = v.orin;
        seq_zero = v.zero; seq_cin = v.cin; seq_re = v.re; seq_fe = v.fe; seq_pup = v.pup;
        seq_exp.push_back({v.y, v.cout});
        seq_name.push_back(n);
    endtask

    task automatic test_reset();
        alu_vec_t   av_t [2];
        seq_vec_t   sv_t [2];
        logic [7:0] ga, ea;
        logic [4:0] gs, es;
        string      nm;
        av_t[0] = av(3'd4, 3'd3, 3'd1, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        av_t[1] = av(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
        sv_t[0] = sq(2'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        sv_t[1] = sq(2'd1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_alu($sformatf("reset_alu%0d", i), av_t[i]);
            drive_seq($sformatf("reset_seq%0d", i), sv_t[i]);
            #1;
            ga = {alu_yout, alu_cout, alu_f0, alu_f3, alu_ovr};
            ea = alu_exp.pop_front(); nm = alu_name.pop_front();
            checks++;
            if (ga !== ea) begin errors++; $display("FAIL %s got %h expected %h", nm, ga, ea); end
            gs = {seq_yout, seq_cout};
            es = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (gs !== es) begin errors++; $display("FAIL %s got %h expected %h", nm, gs, es); end
        end
    endtask

    task automatic test_alu_dest();
        alu_vec_t   v [17];
        logic [7:0] got, exp;
        string      nm;
        v[0]  = av(3'd7, 3'd3, 3'd3, 4'h0, 4'h5, 4'h9, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0); // R5<-9
        v[1]  = av(3'd3, 3'd0, 3'd1, 4'h0, 4'h5, 4'h0, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0);
        v[2]  = av(3'd7, 3'd3, 3'd3, 4'h0, 4'h5, 4'h8, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0); // R5<-8
        v[3]  = av(3'd5, 3'd0, 3'd1, 4'h5, 4'h0, 4'h8, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        v[4]  = av(3'd7, 3'd3, 3'd0, 4'h0, 4'h0, 4'h6, 1'b0, 4'h6, 4'h6, 1'b0, 1'b0); // Q<-6
        v[5]  = av(3'd7, 3'd3, 3'd4, 4'h0, 4'h2, 4'h3, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0); // R2<-1,Q<-3
        v[6]  = av(3'd2, 3'd3, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0);
        v[7]  = av(3'd3, 3'd3, 3'd1, 4'h0, 4'h2, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0);
        v[8]  = av(3'd7, 3'd3, 3'd6, 4'h0, 4'h3, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0); // Q<-6
        v[9]  = av(3'd2, 3'd3, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h6, 4'h6, 1'b0, 1'b0);
        v[10] = av(3'd7, 3'd3, 3'd7, 4'h0, 4'h4, 4'h9, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0); // R4<-2
        v[11] = av(3'd4, 3'd3, 3'd1, 4'h4, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        v[12] = av(3'd7, 3'd3, 3'd5, 4'h0, 4'h4, 4'h9, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0); // R4<-4
        v[13] = av(3'd4, 3'd3, 3'd1, 4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 4'h4, 1'b0, 1'b0);
        v[14] = av(3'd7, 3'd3, 3'd2, 4'h5, 4'h6, 4'hC, 1'b0, 4'h8, 4'hC, 1'b0, 1'b0); // Y=A port
        v[15] = av(3'd3, 3'd0, 3'd3, 4'h0, 4'h6, 4'h0, 1'b1, 4'hD, 4'hD, 1'b0, 1'b0); // R6++
        v[16] = av(3'd3, 3'd3, 3'd1, 4'h0, 4'h6, 4'h0, 1'b0, 4'hD, 4'hD, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            drive_alu($sformatf("alu_dest%0d", i), v[i]);
            #1;
            got = {alu_yout, alu_cout, alu_f0, alu_f3, alu_ovr};
            exp = alu_exp.pop_front(); nm = alu_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        alu_vec_t   v [13];
        logic [7:0] got, exp;
        string      nm;
        v[0]  = av(3'd7, 3'd3, 3'd3, 4'h0, 4'h7, 4'h6, 1'b0, 4'h6, 4'h6, 1'b0, 1'b0); // R7<-6
        v[1]  = av(3'd5, 3'd0, 3'd1, 4'h7, 4'h0, 4'hA, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        v[2]  = av(3'd5, 3'd1, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'hC, 4'hC, 1'b0, 1'b1);
        v[3]  = av(3'd5, 3'd2, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'h4, 4'h4, 1'b1, 1'b1);
        v[4]  = av(3'd5, 3'd3, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'hE, 4'hE, 1'b0, 1'b0);
        v[5]  = av(3'd5, 3'd4, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0);
        v[6]  = av(3'd5, 3'd5, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'h4, 4'h4, 1'b0, 1'b0);
        v[7]  = av(3'd5, 3'd6, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'hC, 4'hC, 1'b0, 1'b0);
        v[8]  = av(3'd5, 3'd7, 3'd1, 4'h7, 4'h0, 4'hA, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
        v[9]  = av(3'd1, 3'd3, 3'd1, 4'h7, 4'h5, 4'h0, 1'b0, 4'hE, 4'hE, 1'b0, 1'b0);
        v[10] = av(3'd1, 3'd1, 3'd1, 4'h7, 4'h5, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 1'b1);
        v[11] = av(3'd0, 3'd6, 3'd1, 4'h7, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        v[12] = av(3'd6, 3'd3, 3'd1, 4'h0, 4'h0, 4'h1, 1'b0, 4'h7, 4'h7, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            drive_alu($sformatf("alu_op%0d", i), v[i]);
            #1;
            got = {alu_yout, alu_cout, alu_f0, alu_f3, alu_ovr};
            exp = alu_exp.pop_front(); nm = alu_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
    endtask

    task automatic test_seq_count();
        logic [4:0] got, exp;
        string      nm;
        for (int i = 0; i < 17; i++) begin
            drive_seq($sformatf("seq_count%0d", i),
                      sq(2'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i), (i == 15)));
            #1;
            got = {seq_yout, seq_cout};
            exp = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_seq_stack();
        seq_vec_t   v [14];
        logic [4:0] got, exp;
        string      nm;
        v[0] = sq(2'd3, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0); // uPC<-3
        v[1] = sq(2'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0); // push 3
        v[2] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0); // pop
        v[3] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0); // SP=0
        for (int i = 0; i < 5; i++) begin
            v[4+i] = sq(2'd3, 4'(9 + i), 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'(9 + i), 1'b0);
        end
        // Five pushes wrap the 4-entry stack; pops then read C,B,A,9,C.
        v[9]  = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0);
        v[10] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB, 1'b0);
        v[11] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0);
        v[12] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0);
        v[13] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 1'b0);
        for (int i = 0; i < 14; i++) begin
            drive_seq($sformatf("seq_stack%0d", i), v[i]);
            #1;
            got = {seq_yout, seq_cout};
            exp = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_seq_zero();
        seq_vec_t   v [6];
        logic [4:0] got, exp;
        string      nm;
        for (int i = 0; i < 4; i++) begin
            v[i] = sq(2'(i), 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        end
        v[4] = sq(2'd3, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1);
        v[5] = sq(2'd3, 4'hE, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_seq($sformatf("seq_zero%0d", i), v[i]);
            #1;
            got = {seq_yout, seq_cout};
            exp = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_seq_ar();
        seq_vec_t   v [4];
        logic [4:0] got, exp;
        string      nm;
        v[0] = sq(2'd3, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0); // AR load
        v[1] = sq(2'd1, 4'h0, 4'h9, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, AR_Y, 1'b0);
        v[2] = sq(2'd1, 4'h0, 4'h9, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, AR_Y, 1'b0);
        v[3] = sq(2'd3, 4'h8, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, OR_Y, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_seq($sformatf("seq_ar%0d", i), v[i]);
            #1;
            got = {seq_yout, seq_cout};
            exp = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s got %h expected %h", nm, got, exp); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_clear();
        alu_vec_t   av_t [3];
        seq_vec_t   sv_t [3];
        logic [7:0] ga, ea;
        logic [4:0] gs, es;
        string      nm;
        av_t[0] = av(3'd3, 3'd3, 3'd1, 4'h0, 4'h5, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        av_t[1] = av(3'd2, 3'd3, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        av_t[2] = av(3'd3, 3'd3, 3'd1, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        sv_t[0] = sq(2'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        sv_t[1] = sq(2'd2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        sv_t[2] = sq(2'd1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu($sformatf("clear_alu%0d", i), av_t[i]);
            drive_seq($sformatf("clear_seq%0d", i), sv_t[i]);
            #1;
            ga = {alu_yout, alu_cout, alu_f0, alu_f3, alu_ovr};
            ea = alu_exp.pop_front(); nm = alu_name.pop_front();
            checks++;
            if (ga !== ea) begin errors++; $display("FAIL %s got %h expected %h", nm, ga, ea); end
            gs = {seq_yout, seq_cout};
            es = seq_exp.pop_front(); nm = seq_name.pop_front();
            checks++;
            if (gs !== es) begin errors++; $display("FAIL %s got %h expected %h", nm, gs, es); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        #2;
        test_reset();
        set_idle();
        @(negedge clock);
        reset = 1'b1;
        tick();
        test_alu_dest();
        test_alu_ops();
        set_idle();
        test_seq_count();
        test_seq_stack();
        test_seq_zero();
        test_seq_ar();
        test_reset_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
